// File: rtl/bus_control_sequencer_if.sv
// bus_control_sequencer_if: instruction/handshake inputs and datapath control strobes
interface bus_control_sequencer_if;
    logic [31:0] IR;
    logic        mem_done;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic        PCout;
    logic        Zlowout;
    logic        Zhighout;
    logic        MDRout;
    logic        HIout;
    logic        LOout;
    logic        Cout;
    logic        PCin;
    logic        MARin;
    logic        MDRin;
    logic        IRin;
    logic        Yin;
    logic        Zin;
    logic        HIin;
    logic        LOin;
    logic        IncPc;
    logic        read;
    logic        write;
    logic [3:0]  control;
    logic        run;
    logic        err;
    modport master (
        input  IR, mem_done,
        output Rin, Rout, PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout,
               PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
               IncPc, read, write, control, run, err
    );
    modport slave (
        output IR, mem_done,
        input  Rin, Rout, PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout,
               PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
               IncPc, read, write, control, run, err
    );
endinterface

// File: rtl/bus_control_sequencer.sv
// bus_control_sequencer: fetch/decode/execute step sequencer driving the single-bus datapath
module bus_control_sequencer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input logic                     clk,
    input logic                     reset,
    bus_control_sequencer_if.master bus
);
    typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam int WW = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_WAIT_MAX - 1);
    state_t        state, state_nx;
    logic [WW-1:0] wait_cnt;
    logic          err_q;
    logic [4:0]    op;
    logic [3:0]    ra, rb, rc;
    logic          is_alu, is_imm, is_ld, is_st, is_mul, is_exec;
    logic          mem_step, stall, timeout;
    assign op      = bus.IR[31:27];
    assign ra      = bus.IR[26:23];
    assign rb      = bus.IR[22:19];
    assign rc      = bus.IR[18:15];
    assign is_alu  = op >= OP_ADD && op <= OP_OR;
    assign is_imm  = op == OP_ADDI || op == OP_LDI;
    assign is_ld   = op == OP_LD;
    assign is_st   = op == OP_ST;
    assign is_mul  = op == OP_MUL;
    assign is_exec = is_alu || is_imm || is_ld || is_st || is_mul;
    // a memory step is any state that waits on mem_done
    assign mem_step = state == T1 || (state == T6 && is_ld) || (state == T7 && is_st);
    assign stall    = mem_step && !bus.mem_done;
    assign timeout  = stall && wait_cnt == WAIT_LAST;
    // state, stall counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= T0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= (stall && !timeout) ? wait_cnt + 1'b1 : '0;
            err_q    <= err_q | timeout;
        end
    end
    // step sequencing from the decoded opcode and the memory handshake
    always_comb begin
        state_nx = state;
        case (state)
            T0:      state_nx = T1;
            T1:      state_nx = bus.mem_done ? T2 : T1;
            T2:      state_nx = T3;
            T3:      state_nx = op == OP_HALT ? HALT : is_exec ? T4 : T0;
            T4:      state_nx = T5;
            T5:      state_nx = (is_ld || is_st || is_mul) ? T6 : T0;
            T6:      state_nx = is_ld ? (bus.mem_done ? T7 : T6) : is_st ? T7 : T0;
            T7:      state_nx = (is_st && !bus.mem_done) ? T7 : T0;
            default: state_nx = HALT;
        endcase
        if (timeout) state_nx = HALT;
    end
    // control strobes per step; everything is forced low while reset is held
    always_comb begin
        bus.Rin      = '0;
        bus.Rout     = '0;
        bus.PCout    = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.MDRout   = 1'b0;
        bus.HIout    = 1'b0;
        bus.LOout    = 1'b0;
        bus.Cout     = 1'b0;
        bus.PCin     = 1'b0;
        bus.MARin    = 1'b0;
        bus.MDRin    = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.IncPc    = 1'b0;
        bus.read     = 1'b0;
        bus.write    = 1'b0;
        bus.control  = 4'b0000;
        bus.run      = !reset && state != HALT;
        bus.err      = !reset && err_q;
        if (!reset) begin
            case (state)
                T0: begin
                    bus.PCout = 1'b1;
                    bus.MARin = 1'b1;
                    bus.IncPc = 1'b1;
                    bus.Zin   = 1'b1;
                end
                T1: begin
                    bus.Zlowout = 1'b1;
                    bus.PCin    = 1'b1;
                    bus.read    = 1'b1;
                    bus.MDRin   = bus.mem_done;
                end
                T2: begin
                    bus.MDRout = 1'b1;
                    bus.IRin   = 1'b1;
                end
                T3: begin
                    bus.Rout = !is_exec ? 16'h0000 : is_mul ? 16'b1 << ra : 16'b1 << rb;
                    bus.Yin  = is_exec;
                end
                T4: begin
                    bus.Zin     = 1'b1;
                    bus.Rout    = is_mul ? 16'b1 << rb : is_alu ? 16'b1 << rc : 16'h0000;
                    bus.Cout    = !is_mul && !is_alu;
                    bus.control = is_mul ? 4'b0100 : is_alu ? 4'(op - OP_ADD) : 4'b0000;
                end
                T5: begin
                    bus.Zlowout = 1'b1;
                    bus.LOin    = is_mul;
                    bus.MARin   = is_ld || is_st;
                    bus.Rin     = (is_alu || is_imm) ? 16'b1 << ra : 16'h0000;
                end
                T6: begin
                    bus.read     = is_ld;
                    bus.MDRin    = is_st || (is_ld && bus.mem_done);
                    bus.Rout     = is_st ? 16'b1 << ra : 16'h0000;
                    bus.Zhighout = is_mul;
                    bus.HIin     = is_mul;
                end
                T7: begin
                    bus.MDRout = is_ld;
                    bus.Rin    = is_ld ? 16'b1 << ra : 16'h0000;
                    bus.write  = is_st;
                end
                default: ;
            endcase
        end
    end
endmodule
